// File: rtl/instr_decode_stage_pkg.sv
// Shared defaults and the decoded-bundle layout for the instruction decode stage.
package instr_decode_stage_pkg;

    localparam int INSTR_W_DEF = 16;
    localparam int OPC_W_DEF   = 4;
    localparam int REG_W_DEF   = 4;
    localparam int IMM_W_DEF   = 8;
    localparam int DATA_W_DEF  = 16;
    localparam int CNT_W_DEF   = 8;

    // Bundle at default widths; modules re-declare it locally with their own parameters.
    typedef struct packed {
        logic [OPC_W_DEF-1:0]  opcode;
        logic [REG_W_DEF-1:0]  rd;
        logic [REG_W_DEF-1:0]  rs;
        logic [REG_W_DEF-1:0]  rt;
        logic [DATA_W_DEF-1:0] imm;
        logic                  illegal;
    } dec_bundle_t;

endpackage

// File: rtl/instr_decode_stage_if.sv
// Upstream instruction handshake and downstream decoded-bundle handshake.
interface instr_decode_stage_if
    import instr_decode_stage_pkg::*;
#(
    parameter int INSTR_W = INSTR_W_DEF,
    parameter int OPC_W   = OPC_W_DEF,
    parameter int REG_W   = REG_W_DEF,
    parameter int DATA_W  = DATA_W_DEF
);
    logic               in_valid;
    logic               in_ready;
    logic [INSTR_W-1:0] in_instr;
    logic               out_valid;
    logic               out_ready;
    logic [OPC_W-1:0]   out_opcode;
    logic [REG_W-1:0]   out_rd;
    logic [REG_W-1:0]   out_rs;
    logic [REG_W-1:0]   out_rt;
    logic [DATA_W-1:0]  out_imm;
    logic               out_illegal;

    // Environment side: supplies instructions and consumes bundles.
    modport master (
        output in_valid, in_instr, out_ready,
        input  in_ready, out_valid, out_opcode, out_rd, out_rs, out_rt, out_imm, out_illegal
    );

    // Decode stage side.
    modport slave (
        input  in_valid, in_instr, out_ready,
        output in_ready, out_valid, out_opcode, out_rd, out_rs, out_rt, out_imm, out_illegal
    );
endinterface

// File: rtl/instr_decode_stage_field_decode.sv
// Purely combinational split of an instruction word into a flattened decoded bundle.
module instr_field_decode
    import instr_decode_stage_pkg::*;
#(
    parameter int INSTR_W = INSTR_W_DEF,
    parameter int OPC_W   = OPC_W_DEF,
    parameter int REG_W   = REG_W_DEF,
    parameter int IMM_W   = IMM_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter logic [(2**OPC_W)-1:0] LEGAL_MASK = '1,
    parameter int BUNDLE_W = OPC_W + 3*REG_W + DATA_W + 1
)
(
    input  logic [INSTR_W-1:0]  i_instr,
    output logic [BUNDLE_W-1:0] o_bundle
);
    typedef struct packed {
        logic [OPC_W-1:0]  opcode;
        logic [REG_W-1:0]  rd;
        logic [REG_W-1:0]  rs;
        logic [REG_W-1:0]  rt;
        logic [DATA_W-1:0] imm;
        logic              illegal;
    } bundle_t;

    bundle_t w_bundle;

    // Register fields sit back to back directly below the opcode.
    always_comb begin
        w_bundle         = '0;
        w_bundle.opcode  = i_instr[INSTR_W-1 -: OPC_W];
        w_bundle.rd      = i_instr[INSTR_W-OPC_W-1 -: REG_W];
        w_bundle.rs      = i_instr[INSTR_W-OPC_W-REG_W-1 -: REG_W];
        w_bundle.rt      = i_instr[INSTR_W-OPC_W-2*REG_W-1 -: REG_W];
        w_bundle.imm     = DATA_W'($signed(i_instr[IMM_W-1:0]));
        w_bundle.illegal = ~LEGAL_MASK[w_bundle.opcode];
    end

    assign o_bundle = w_bundle;

endmodule

// File: rtl/instr_decode_stage.sv
// Decode stage: one shared decoder feeding an output register plus a skid register.
module instr_decode_stage
    import instr_decode_stage_pkg::*;
#(
    parameter int INSTR_W = INSTR_W_DEF,
    parameter int OPC_W   = OPC_W_DEF,
    parameter int REG_W   = REG_W_DEF,
    parameter int IMM_W   = IMM_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter logic [(2**OPC_W)-1:0] LEGAL_MASK = '1,
    parameter int CNT_W   = CNT_W_DEF
)
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    instr_decode_stage_if.slave  bus,
    output logic [CNT_W-1:0]     illegal_cnt
);
    typedef struct packed {
        logic [OPC_W-1:0]  opcode;
        logic [REG_W-1:0]  rd;
        logic [REG_W-1:0]  rs;
        logic [REG_W-1:0]  rt;
        logic [DATA_W-1:0] imm;
        logic              illegal;
    } bundle_t;

    localparam int BUNDLE_W = $bits(bundle_t);

    logic [BUNDLE_W-1:0] w_dec_vec;
    bundle_t             w_dec;
    logic                w_in_ready;
    logic                w_accept;
    logic                w_or_free;
    logic                w_drain;

    logic                r_or_valid;
    logic                r_sr_valid;
    bundle_t             r_or;
    bundle_t             r_sr;
    logic [CNT_W-1:0]    r_illegal_cnt;

    logic                w_or_valid_nxt;
    logic                w_sr_valid_nxt;
    bundle_t             w_or_nxt;
    bundle_t             w_sr_nxt;
    logic [CNT_W-1:0]    w_cnt_nxt;

    instr_field_decode #(
        .INSTR_W    (INSTR_W),
        .OPC_W      (OPC_W),
        .REG_W      (REG_W),
        .IMM_W      (IMM_W),
        .DATA_W     (DATA_W),
        .LEGAL_MASK (LEGAL_MASK),
        .BUNDLE_W   (BUNDLE_W)
    ) u_field_decode (
        .i_instr  (bus.in_instr),
        .o_bundle (w_dec_vec)
    );

    assign w_dec      = bundle_t'(w_dec_vec);
    assign w_in_ready = ~r_sr_valid & rst_n;
    assign w_accept   = bus.in_valid & w_in_ready;
    assign w_or_free  = ~r_or_valid | bus.out_ready;
    assign w_drain    = r_or_valid & bus.out_ready;

    // Buffer steering: OR refills from SR first, then from the decoder; SR only catches a stalled accept.
    always_comb begin
        w_or_valid_nxt = r_or_valid;
        w_sr_valid_nxt = r_sr_valid;
        w_or_nxt       = r_or;
        w_sr_nxt       = r_sr;
        if (flush) begin
            w_or_valid_nxt = 1'b0;
            w_sr_valid_nxt = 1'b0;
        end else if (w_or_free) begin
            if (r_sr_valid) begin
                w_or_nxt       = r_sr;
                w_or_valid_nxt = 1'b1;
                w_sr_valid_nxt = 1'b0;
            end else if (w_accept) begin
                w_or_nxt       = w_dec;
                w_or_valid_nxt = 1'b1;
            end else begin
                w_or_valid_nxt = 1'b0;
            end
        end else begin
            if (w_accept) begin
                w_sr_nxt       = w_dec;
                w_sr_valid_nxt = 1'b1;
            end else begin
                w_sr_valid_nxt = r_sr_valid;
            end
        end
    end

    // Saturating count of illegal bundles taken downstream; flush does not touch it.
    always_comb begin
        w_cnt_nxt = r_illegal_cnt;
        if (w_drain && r_or.illegal && (r_illegal_cnt != {CNT_W{1'b1}})) begin
            w_cnt_nxt = r_illegal_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            w_cnt_nxt = r_illegal_cnt;
        end
    end

    // State registers with asynchronous clear of buffered instructions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_or_valid    <= 1'b0;
            r_sr_valid    <= 1'b0;
            r_or          <= '0;
            r_sr          <= '0;
            r_illegal_cnt <= '0;
        end else begin
            r_or_valid    <= w_or_valid_nxt;
            r_sr_valid    <= w_sr_valid_nxt;
            r_or          <= w_or_nxt;
            r_sr          <= w_sr_nxt;
            r_illegal_cnt <= w_cnt_nxt;
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.out_valid   = r_or_valid;
    assign bus.out_opcode  = r_or.opcode;
    assign bus.out_rd      = r_or.rd;
    assign bus.out_rs      = r_or.rs;
    assign bus.out_rt      = r_or.rt;
    assign bus.out_imm     = r_or.imm;
    assign bus.out_illegal = r_or.illegal;
    assign illegal_cnt     = r_illegal_cnt;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Directed bench: default-parameter instance plus a restricted-opcode, 2-bit-counter instance.
module tb_instr_decode_stage;

    logic       clk;
    logic       rst_n;
    logic       flush_a;
    logic       flush_b;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;
    int         n_total;
    int         n_pass;

    instr_decode_stage_if bus_a();
    instr_decode_stage_if bus_b();

    instr_decode_stage u_dut_a (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush_a),
        .bus         (bus_a),
        .illegal_cnt (cnt_a)
    );

    instr_decode_stage #(
        .LEGAL_MASK (16'h7FFF),
        .CNT_W      (2)
    ) u_dut_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush_b),
        .bus         (bus_b),
        .illegal_cnt (cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        rst_n   = 1'b0;
        flush_a = 1'b0;
        flush_b = 1'b0;
        bus_a.in_valid  = 1'b0;
        bus_a.in_instr  = 16'h0000;
        bus_a.out_ready = 1'b0;
        bus_b.in_valid  = 1'b0;
        bus_b.in_instr  = 16'h0000;
        bus_b.out_ready = 1'b0;

        #1;
        chk("rst_in_ready", {31'd0, bus_a.in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, bus_a.out_valid}, 32'd0);
        chk("rst_opcode", {28'd0, bus_a.out_opcode}, 32'd0);
        chk("rst_imm", {16'd0, bus_a.out_imm}, 32'd0);
        chk("rst_cnt", {24'd0, cnt_a}, 32'd0);
        #11 rst_n = 1'b1;
        step();
        chk("post_rst_in_ready", {31'd0, bus_a.in_ready}, 32'd1);
        chk("post_rst_out_valid", {31'd0, bus_a.out_valid}, 32'd0);

        // Basic decode with downstream always ready.
        bus_a.in_valid  = 1'b1;
        bus_a.in_instr  = 16'h1234;
        bus_a.out_ready = 1'b1;
        step();
        chk("d1234_valid", {31'd0, bus_a.out_valid}, 32'd1);
        chk("d1234_opcode", {28'd0, bus_a.out_opcode}, 32'd1);
        chk("d1234_rd", {28'd0, bus_a.out_rd}, 32'd2);
        chk("d1234_rs", {28'd0, bus_a.out_rs}, 32'd3);
        chk("d1234_rt", {28'd0, bus_a.out_rt}, 32'd4);
        chk("d1234_imm", {16'd0, bus_a.out_imm}, 32'h0034);
        chk("d1234_illegal", {31'd0, bus_a.out_illegal}, 32'd0);
        bus_a.in_instr = 16'h30F0;
        step();
        chk("d30f0_opcode", {28'd0, bus_a.out_opcode}, 32'd3);
        chk("d30f0_imm", {16'd0, bus_a.out_imm}, 32'h0000FFF0);
        bus_a.in_valid = 1'b0;
        step();
        chk("drain_out_valid", {31'd0, bus_a.out_valid}, 32'd0);

        // Back-pressure fills OR then SR, then drains in order.
        bus_a.out_ready = 1'b0;
        bus_a.in_valid  = 1'b1;
        bus_a.in_instr  = 16'hA001;
        step();
        chk("bp1_in_ready", {31'd0, bus_a.in_ready}, 32'd1);
        bus_a.in_instr = 16'hB002;
        step();
        chk("bp2_in_ready", {31'd0, bus_a.in_ready}, 32'd0);
        chk("bp2_opcode", {28'd0, bus_a.out_opcode}, 32'hA);
        bus_a.in_valid = 1'b0;
        step();
        chk("bp_stable_opcode", {28'd0, bus_a.out_opcode}, 32'hA);
        chk("bp_stable_imm", {16'd0, bus_a.out_imm}, 32'h0001);
        bus_a.out_ready = 1'b1;
        step();
        chk("bp_second_opcode", {28'd0, bus_a.out_opcode}, 32'hB);
        chk("bp_second_valid", {31'd0, bus_a.out_valid}, 32'd1);
        chk("bp_second_in_ready", {31'd0, bus_a.in_ready}, 32'd1);
        step();
        chk("bp_empty", {31'd0, bus_a.out_valid}, 32'd0);

        // Flush with both registers full and an offered instruction.
        bus_a.out_ready = 1'b0;
        bus_a.in_valid  = 1'b1;
        bus_a.in_instr  = 16'hC003;
        step();
        bus_a.in_instr = 16'hD004;
        step();
        chk("full_in_ready", {31'd0, bus_a.in_ready}, 32'd0);
        flush_a        = 1'b1;
        bus_a.in_instr = 16'hE005;
        step();
        chk("flush_out_valid", {31'd0, bus_a.out_valid}, 32'd0);
        chk("flush_in_ready", {31'd0, bus_a.in_ready}, 32'd1);
        // Flush while SR empty: the same-cycle accept is dropped too.
        bus_a.in_instr = 16'h1111;
        step();
        chk("flush_drop_accept", {31'd0, bus_a.out_valid}, 32'd0);
        flush_a         = 1'b0;
        bus_a.in_valid  = 1'b0;
        bus_a.out_ready = 1'b1;
        step();
        chk("flush_nothing_emitted", {31'd0, bus_a.out_valid}, 32'd0);
        chk("cnt_a_legal_only", {24'd0, cnt_a}, 32'd0);

        // Illegal opcode F on the restricted instance; 2-bit counter saturates.
        bus_b.out_ready = 1'b1;
        bus_b.in_valid  = 1'b1;
        bus_b.in_instr  = 16'hF000;
        step();
        chk("ill1_flag", {31'd0, bus_b.out_illegal}, 32'd1);
        chk("ill1_cnt", {30'd0, cnt_b}, 32'd0);
        step();
        chk("ill2_cnt", {30'd0, cnt_b}, 32'd1);
        step();
        chk("ill3_flag", {31'd0, bus_b.out_illegal}, 32'd1);
        chk("ill3_cnt", {30'd0, cnt_b}, 32'd2);
        step();
        chk("ill_three_drained", {30'd0, cnt_b}, 32'd3);
        step();
        bus_b.in_instr = 16'h1234;
        step();
        chk("ill_saturated", {30'd0, cnt_b}, 32'd3);
        chk("b_legal_flag", {31'd0, bus_b.out_illegal}, 32'd0);
        bus_b.in_valid = 1'b0;
        step();
        chk("b_legal_no_count", {30'd0, cnt_b}, 32'd3);

        // Asynchronous reset between edges with a bundle held in OR.
        bus_a.out_ready = 1'b0;
        bus_a.in_valid  = 1'b1;
        bus_a.in_instr  = 16'h9009;
        step();
        bus_a.in_valid = 1'b0;
        chk("pre_rst_valid", {31'd0, bus_a.out_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {31'd0, bus_a.out_valid}, 32'd0);
        chk("async_rst_cnt_b", {30'd0, cnt_b}, 32'd0);
        chk("async_rst_in_ready", {31'd0, bus_a.in_ready}, 32'd0);
        #2 rst_n = 1'b1;
        step();
        chk("rel_out_valid", {31'd0, bus_a.out_valid}, 32'd0);
        chk("rel_in_ready", {31'd0, bus_a.in_ready}, 32'd1);
        bus_a.out_ready = 1'b1;
        step();
        chk("rel_no_stale", {31'd0, bus_a.out_valid}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
